// File: rtl/fpcvt_pkg.sv
// Shared constants for the fixed-to-float converter: rounding-mode codes and exponent range.
// No logic; no latency; no backpressure.
// Imported by the pipeline top.
package fpcvt_pkg;

    localparam logic [1:0] RND_TRUNC  = 2'd0;
    localparam logic [1:0] RND_HALFUP = 2'd1;
    localparam logic [1:0] RND_RNE    = 2'd2;

    // Largest exponent the converter can produce: magnitude bits above the significand.
    function automatic int fpcvt_emax(input int in_w, input int man_w);
        return in_w - 1 - man_w;
    endfunction

endpackage

// File: rtl/fpcvt_if.sv
// Sample-in / float-out stream bundle with valid/ready on both sides.
// Master = sample source + result sink; slave = converter.
interface fpcvt_if #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;

    logic             out_valid;
    logic             out_ready;
    logic             out_s;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_f;
    logic             out_sat;
    logic             out_inexact;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_s, out_e, out_f, out_sat, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_s, out_e, out_f, out_sat, out_inexact
    );

endinterface

// File: rtl/fpcvt_lzd.sv
// Leading-one detector: index of the highest set bit of vec, found=0 when vec is zero.
// Purely combinational, zero latency.
// No backpressure (no state).
module fpcvt_lzd #(
    parameter  int W  = 11,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan upward so the last hit, the most significant one, wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// Signed fixed-point sample to sign/exponent/significand float with rounding and sat/inexact flags.
// Latency 3 cycles (S1 magnitude, S2 normalise, S3 round), 1 sample/cycle.
// Elastic stages: each register holds under out_ready=0; in_ready drops once all three are full.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int MAN_W = 4,
    parameter int EXP_W = 3
) (
    input logic   clk,
    input logic   rst_n,
    fpcvt_if.slave io
);

    localparam int M    = IN_W - 1;
    localparam int EMAX = fpcvt_emax(IN_W, MAN_W);
    localparam int PW   = $clog2(M);
    localparam int SW   = PW + 1;

    if ((MAN_W < 2) || (MAN_W > M) || (((2 ** EXP_W) - 1) < EMAX)) begin : g_bad_params
        $error("fpcvt_pipe: MAN_W must lie in [2, IN_W-1] and EXP_W must cover IN_W-1-MAN_W");
    end

    typedef struct packed {
        logic         s;
        logic [M-1:0] mag;
        logic         clamp;
        logic [1:0]   mode;
    } s1_t;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic             r;
        logic             st;
        logic             clamp;
        logic [1:0]       mode;
    } s2_t;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic             sat;
        logic             inexact;
    } s3_t;

    logic v1, v2, v3;
    logic en1, en2, en3;
    s1_t  st1, st1_n;
    s2_t  st2, st2_n;
    s3_t  st3, st3_n;

    // A stage loads when empty or when its current occupant moves on this cycle.
    assign en3         = ~v3 | io.out_ready;
    assign en2         = ~v2 | en3;
    assign en1         = ~v1 | en2;
    assign io.in_ready = en1;

    logic [M-1:0] neg;

    always_comb begin
        st1_n       = '0;
        st1_n.s     = io.in_data[IN_W-1];
        st1_n.mode  = io.in_mode;
        neg         = -io.in_data[M-1:0];
        st1_n.mag   = st1_n.s ? neg : io.in_data[M-1:0];
        // -2^M has no positive counterpart in M bits; pin it to the largest magnitude.
        st1_n.clamp = st1_n.s && (neg == '0);
        if (st1_n.clamp) begin
            st1_n.mag = '1;
        end
    end

    logic [PW-1:0] lz_idx;
    logic          lz_found;

    fpcvt_lzd #(.W(M)) u_lzd (
        .vec   (st1.mag),
        .idx   (lz_idx),
        .found (lz_found)
    );

    logic [SW-1:0] sh;
    logic [M-1:0]  rbit;

    always_comb begin
        st2_n       = '0;
        st2_n.s     = st1.s;
        st2_n.clamp = st1.clamp;
        st2_n.mode  = st1.mode;
        st2_n.f     = st1.mag[MAN_W-1:0];
        sh          = '0;
        rbit        = '0;
        if (lz_found && ({1'b0, lz_idx} >= SW'(MAN_W))) begin
            // Shift so the leading one lands in the significand MSB; the shift is the exponent.
            sh       = {1'b0, lz_idx} - SW'(MAN_W - 1);
            rbit     = M'(1) << (sh - SW'(1));
            st2_n.e  = EXP_W'(sh);
            st2_n.f  = MAN_W'(st1.mag >> sh);
            st2_n.r  = |(st1.mag & rbit);
            st2_n.st = |(st1.mag & (rbit - M'(1)));
        end
    end

    logic inc;

    always_comb begin
        case (st2.mode)
            RND_TRUNC:  inc = 1'b0;
            RND_HALFUP: inc = st2.r;
            RND_RNE:    inc = st2.r & (st2.st | st2.f[0]);
            default:    inc = 1'b0;
        endcase

        st3_n.s       = st2.s;
        st3_n.e       = st2.e;
        st3_n.f       = st2.f;
        st3_n.sat     = st2.clamp;
        st3_n.inexact = st2.r | st2.st | st2.clamp;

        if (inc) begin
            if (~&st2.f) begin
                st3_n.f = st2.f + MAN_W'(1);
            end else if (st2.e < EXP_W'(EMAX)) begin
                st3_n.e = st2.e + EXP_W'(1);
                st3_n.f = {1'b1, {(MAN_W-1){1'b0}}};
            end else begin
                st3_n.sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            st1 <= '0;
            st2 <= '0;
            st3 <= '0;
        end else begin
            if (en1) begin
                v1 <= io.in_valid;
                if (io.in_valid) st1 <= st1_n;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) st2 <= st2_n;
            end
            if (en3) begin
                v3 <= v2;
                if (v2) st3 <= st3_n;
            end
        end
    end

    assign io.out_valid   = v3;
    assign io.out_s       = st3.s;
    assign io.out_e       = st3.e;
    assign io.out_f       = st3.f;
    assign io.out_sat     = st3.sat;
    assign io.out_inexact = st3.inexact;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: directed vectors, backpressure burst, random out_ready, mid-stream reset.
module tb_fpcvt_pipe;

    localparam int IN_W  = 12;
    localparam int MAN_W = 4;
    localparam int EXP_W = 3;
    localparam int EMAX  = 7;
    localparam int NDIR  = 17;

    typedef struct {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic             sat;
        logic             inex;
        int               acc;
        bit               lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   ready_mode = 0;
    exp_t q[$];

    fpcvt_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) io ();

    fpcvt_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors: {s, e[2:0], f[3:0], sat, inexact}, hand-derived.
    logic [IN_W-1:0] dir_d [NDIR] = '{12'd13, 12'd0, 12'd62, 12'd62, 12'd17, 12'd17, 12'd19,
                                      12'h800, 12'h800, 12'd2047, 12'd2047, 12'd2047, 12'hFC2,
                                      12'hFF3, 12'd3, 12'd16, 12'd15};
    logic [1:0]      dir_m [NDIR] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                      2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1,
                                      2'd3, 2'd2, 2'd1, 2'd1};
    logic [9:0]      dir_x [NDIR] = '{{1'b0, 3'd0, 4'd13, 1'b0, 1'b0},
                                      {1'b0, 3'd0, 4'd0,  1'b0, 1'b0},
                                      {1'b0, 3'd2, 4'd15, 1'b0, 1'b1},
                                      {1'b0, 3'd3, 4'd8,  1'b0, 1'b1},
                                      {1'b0, 3'd1, 4'd9,  1'b0, 1'b1},
                                      {1'b0, 3'd1, 4'd8,  1'b0, 1'b1},
                                      {1'b0, 3'd1, 4'd10, 1'b0, 1'b1},
                                      {1'b1, 3'd7, 4'd15, 1'b1, 1'b1},
                                      {1'b1, 3'd7, 4'd15, 1'b1, 1'b1},
                                      {1'b0, 3'd7, 4'd15, 1'b1, 1'b1},
                                      {1'b0, 3'd7, 4'd15, 1'b0, 1'b1},
                                      {1'b0, 3'd7, 4'd15, 1'b1, 1'b1},
                                      {1'b1, 3'd3, 4'd8,  1'b0, 1'b1},
                                      {1'b1, 3'd0, 4'd13, 1'b0, 1'b0},
                                      {1'b0, 3'd0, 4'd3,  1'b0, 1'b0},
                                      {1'b0, 3'd1, 4'd8,  1'b0, 1'b0},
                                      {1'b0, 3'd0, 4'd15, 1'b0, 1'b0}};

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t from_vec(input logic [9:0] v);
        exp_t r;
        r.s = v[9]; r.e = v[8:6]; r.f = v[5:2]; r.sat = v[1]; r.inex = v[0];
        r.acc = 0; r.lat = 1'b0;
        return r;
    endfunction

    // Arithmetic reference: scale down by powers of two, then round on the discarded bits.
    function automatic exp_t model(input logic [IN_W-1:0] d, input logic [1:0] m);
        exp_t r;
        int v, mag, e, f, rb, st, inc, sat, clamp;
        v = int'(d);
        r.s = d[IN_W-1];
        mag = r.s ? (1 << IN_W) - v : v;
        clamp = 0;
        if (mag == (1 << (IN_W - 1))) begin mag = mag - 1; clamp = 1; end
        e = 0;
        while ((mag >> e) >= (1 << MAN_W)) e++;
        f  = mag >> e;
        rb = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
        st = (e > 1) ? (((mag & ((1 << (e - 1)) - 1)) != 0) ? 1 : 0) : 0;
        inc = (m == 2'd1) ? rb : ((m == 2'd2) ? (rb & (st | (f & 1))) : 0);
        sat = clamp;
        if (inc != 0) begin
            f++;
            if (f == (1 << MAN_W)) begin
                if (e < EMAX) begin e++; f = 1 << (MAN_W - 1); end
                else begin f = (1 << MAN_W) - 1; sat = 1; end
            end
        end
        r.e = EXP_W'(e); r.f = MAN_W'(f); r.sat = sat[0];
        r.inex = (rb | st | clamp) != 0;
        r.acc = 0; r.lat = 1'b0;
        return r;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
    task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m, input exp_t ex);
        int n = 0;
        io.in_valid = 1'b1; io.in_data = d; io.in_mode = m;
        forever begin
            @(negedge clk);
            if (io.in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                io.in_valid = 1'b0;
                return;
            end
        end
        ex.acc = cyc;
        q.push_back(ex);
        acc_cnt++;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
        check("drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = 1'($urandom_range(0, 1));
                default: io.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks held outputs stay put.
    initial begin
        exp_t       ex;
        bit         held = 1'b0;
        logic [9:0] prev = '0;
        logic [9:0] cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin held = 1'b0; continue; end
            cur = {io.out_s, io.out_e, io.out_f, io.out_sat, io.out_inexact};
            if (held && io.out_valid) check("hold_stable", int'(cur), int'(prev));
            held = io.out_valid && !io.out_ready;
            prev = cur;
            if (io.out_valid && io.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    ex = q.pop_front();
                    check("result", int'(cur), int'({ex.s, ex.e, ex.f, ex.sat, ex.inex}));
                    if (ex.lat) check("latency", cyc - ex.acc, 3);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t, want < 1000000", $time);
        $fatal(1);
    end

    initial begin
        int         n;
        exp_t       ex;
        logic [IN_W-1:0] d;
        logic [1:0] m;

        io.in_valid = 1'b0; io.in_data = '0; io.in_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(io.out_valid), 0);
        check("rst_outputs", int'({io.out_s, io.out_e, io.out_f, io.out_sat, io.out_inexact}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(io.in_ready), 1);

        for (int i = 0; i < NDIR; i++) begin
            ex = from_vec(dir_x[i]);
            ex.lat = (i == 0);
            send(dir_d[i], dir_m[i], ex);
        end
        drain();

        // Backpressure burst: eight back-to-back samples against a stalled sink.
        ready_mode = 2;
        @(posedge clk); #2;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = IN_W'(100 + i * 213);
                    m = 2'(i % 3);
                    send(d, m, model(d, m));
                end
            end
            begin
                int nb = 0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", int'(io.in_ready), 0);
                check("bp_held", acc_cnt, 3);
                ready_mode = 0;
                @(posedge clk);
                repeat (8) begin
                    @(negedge clk);
                    if (io.out_valid && io.out_ready) nb++;
                end
                check("bp_burst", nb, 8);
            end
        join
        drain();

        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            d = IN_W'($urandom);
            m = 2'($urandom_range(0, 3));
            send(d, m, model(d, m));
            if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        drain();

        // Mid-stream reset with three samples held in the pipe.
        ready_mode = 2;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            d = IN_W'(300 + i);
            send(d, 2'd0, model(d, 2'd0));
        end
        check("pre_rst_valid", int'(io.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(io.out_valid), 0);
        q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (io.out_valid) n++;
        end
        check("no_stale", n, 0);
        @(posedge clk); #1;
        ex = from_vec({1'b0, 3'd0, 4'd5, 1'b0, 1'b0});
        ex.lat = 1'b1;
        send(12'd5, 2'd0, ex);
        drain();

        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
